// File: rtl/iq_alloc_sel_ctrl.sv
// iq_alloc_sel_ctrl: allocation and oldest-ready selection for one issue queue.
//   - Up to DISP_WIDTH instructions are placed into free entries per cycle;
//     the whole group is accepted or none of it is.
//   - An age matrix orders the valid entries. The oldest candidate is strobed
//     by sel_o and loaded into a one-deep issue register with valid/ready.
//   - flush strobes sel_o to every entry and empties the issue register.
// Optional build macro IQ_STALL_CNT_EN adds stall_cnt_o. It counts the cycles
// in which slot 0 requests dispatch and the group is not accepted.
module iq_alloc_sel_ctrl #(
  parameter int IQ_DEPTH   = 8,
  parameter int DISP_WIDTH = 2,
  parameter int IDX_W      = $clog2(IQ_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [DISP_WIDTH-1:0]       disp_valid_i,
  output logic                        disp_ready_o,
  output logic [DISP_WIDTH*IDX_W-1:0] disp_idx_o,
  output logic [IQ_DEPTH-1:0]         updata_o,
  input  logic [IQ_DEPTH-1:0]         entry_valid_i,
  input  logic [IQ_DEPTH-1:0]         entry_rdy_i,
  output logic [IQ_DEPTH-1:0]         sel_o,
  output logic                        issue_valid_o,
  output logic [IDX_W-1:0]            issue_idx_o,
  input  logic                        issue_ready_i,
  output logic [IDX_W:0]              free_cnt_o
`ifdef IQ_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt_o
`endif
);

  // The group size, sized to match free_cnt_o so the acceptance test is a
  // plain same-width compare.
  localparam logic [IDX_W:0] DISP_W_C = (IDX_W+1)'(DISP_WIDTH);

  logic [IQ_DEPTH-1:0]                 free_vec;
  logic [IDX_W-1:0]                    slot_idx [DISP_WIDTH];
  logic [DISP_WIDTH-1:0]               alloc;
  logic [IQ_DEPTH-1:0]                 cand;
  logic                                cand_any;
  logic [IDX_W-1:0]                    oldest_idx;
  logic                                load;

  // age_q[i][j] = 1 means entry i is older than entry j.
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]   age_q, age_d;
  // Entries strobed by sel_o last cycle. They still report valid for one
  // cycle, so they must be kept out of the candidate set.
  logic [IQ_DEPTH-1:0]                 pending_q, pending_d;
  logic                                issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0]                    issue_idx_q, issue_idx_d;

  assign free_vec = ~entry_valid_i;

  // Count the free entries.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // logic. This keeps every path assigned, so no latch is inferred.
    free_cnt_o = '0;
    for (int e = 0; e < IQ_DEPTH; e++) begin
      free_cnt_o = free_cnt_o + (IDX_W+1)'(free_vec[e]);
    end
  end

  // Give slot k the k-th lowest-index free entry.
  always_comb begin
    int rank;
    rank = 0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      slot_idx[k] = '0;
    end
    for (int e = 0; e < IQ_DEPTH; e++) begin
      if (free_vec[e]) begin
        for (int k = 0; k < DISP_WIDTH; k++) begin
          if (rank == k) begin
            slot_idx[k] = IDX_W'(e);
          end
        end
        rank = rank + 1;
      end
    end
  end

  // Accept the whole group only when every slot can be placed. Write strobes
  // go only to the slots that actually carry an instruction.
  always_comb begin
    disp_ready_o = ~flush & (free_cnt_o >= DISP_W_C);
    alloc        = disp_valid_i & {DISP_WIDTH{disp_ready_o}};
    updata_o     = '0;
    disp_idx_o   = '0;
    for (int k = 0; k < DISP_WIDTH; k++) begin
      disp_idx_o[k*IDX_W +: IDX_W] = slot_idx[k];
      if (alloc[k]) begin
        updata_o[slot_idx[k]] = 1'b1;
      end
    end
  end

  // Pick the candidate that no other candidate is older than.
  always_comb begin
    logic blocked;
    blocked    = 1'b0;
    cand       = entry_valid_i & entry_rdy_i & ~pending_q;
    cand_any   = |cand;
    oldest_idx = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (cand[j] && age_q[j][i]) begin
          blocked = 1'b1;
        end
      end
      if (cand[i] && !blocked) begin
        oldest_idx = IDX_W'(i);
      end
    end
  end

  // Strobe the selected entry when the issue register can take it.
  // flush clears every entry.
  always_comb begin
    load = (~issue_valid_q | issue_ready_i) & cand_any & ~flush;
    if (flush) begin
      sel_o = '1;
    end else if (load) begin
      sel_o = IQ_DEPTH'(1) << oldest_idx;
    end else begin
      sel_o = '0;
    end
    pending_d = sel_o;
  end

  // Issue register: load on selection, drain on acceptance, hold otherwise.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_idx_d   = issue_idx_q;
    if (flush) begin
      issue_valid_d = 1'b0;
    end else if (load) begin
      issue_valid_d = 1'b1;
      issue_idx_d   = oldest_idx;
    end else if (issue_ready_i) begin
      issue_valid_d = 1'b0;
    end
  end

  // A newly allocated entry is younger than every surviving valid entry.
  // Within one group, slot 0 is older than slot 1.
  always_comb begin
    age_d = age_q;
    if (flush) begin
      age_d = '0;
    end else begin
      for (int k = 0; k < DISP_WIDTH; k++) begin
        if (alloc[k]) begin
          for (int j = 0; j < IQ_DEPTH; j++) begin
            age_d[slot_idx[k]][j] = 1'b0;
            age_d[j][slot_idx[k]] = entry_valid_i[j] & ~sel_o[j];
          end
        end
      end
      if (DISP_WIDTH == 2 && alloc[0] && alloc[DISP_WIDTH-1]) begin
        age_d[slot_idx[0]][slot_idx[DISP_WIDTH-1]] = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the age matrix is reset explicitly, like any other state flop.
      // After reset no stale ordering may block selection, so it must not be
      // treated as a memory that is left uninitialised.
      age_q         <= '0;
      pending_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout. Every flop samples the
      // values from before the edge, whatever order the statements are in.
      age_q         <= age_d;
      pending_q     <= pending_d;
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_idx_o   = issue_idx_q;

`ifdef IQ_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count the cycles in which dispatch is requested but refused.
  // Only reset clears the counter; flush does not.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(disp_valid_i[0] & ~disp_ready_o);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_iq_alloc_sel_ctrl.sv
// tb_iq_alloc_sel_ctrl: randomized bench for iq_alloc_sel_ctrl.
// The queue entries are modelled here. Each keeps a valid bit, a ready bit
// and an allocation timestamp. Age is taken directly from the timestamps.
// Combinational outputs are compared every cycle. Every issued index goes into
// a scoreboard queue, and a separate monitor checks it at the issue handshake.
module tb_iq_alloc_sel_ctrl;

  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int IW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic [DW-1:0]     disp_valid_i;
  logic              disp_ready_o;
  logic [DW*IW-1:0]  disp_idx_o;
  logic [DEPTH-1:0]  updata_o;
  logic [DEPTH-1:0]  entry_valid_i;
  logic [DEPTH-1:0]  entry_rdy_i;
  logic [DEPTH-1:0]  sel_o;
  logic              issue_valid_o;
  logic [IW-1:0]     issue_idx_o;
  logic              issue_ready_i;
  logic [IW:0]       free_cnt_o;
`ifdef IQ_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
  int unsigned       m_stall;
`endif

  iq_alloc_sel_ctrl #(.IQ_DEPTH(DEPTH), .DISP_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
    .disp_idx_o(disp_idx_o), .updata_o(updata_o),
    .entry_valid_i(entry_valid_i), .entry_rdy_i(entry_rdy_i),
    .sel_o(sel_o), .issue_valid_o(issue_valid_o), .issue_idx_o(issue_idx_o),
    .issue_ready_i(issue_ready_i), .free_cnt_o(free_cnt_o)
`ifdef IQ_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference state: the entries themselves plus the issue stage.
  bit [DEPTH-1:0] m_valid, m_rdy, m_pend;
  int             m_stamp [DEPTH];
  int             stamp_ctr;
  bit             m_iv;
  int             m_iidx;
  int             exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = '0; m_rdy = '0; m_pend = '0; m_iv = 1'b0; m_iidx = 0;
    stamp_ctr = 0;
    exp_q.delete();
    for (int e = 0; e < DEPTH; e++) m_stamp[e] = 0;
`ifdef IQ_STALL_CNT_EN
    m_stall = 0;
`endif
  endtask

  // Reset asserted away from any clock edge; its effect must be immediate.
  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    flush = 1'b0; disp_valid_i = '0; issue_ready_i = 1'b0;
    entry_valid_i = '0; entry_rdy_i = '0;
    #1;
    check("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    check("rst_issue_idx", 32'(issue_idx_o), 32'd0);
    check("rst_free_cnt", 32'(free_cnt_o), DEPTH);
    check("rst_disp_ready", 32'(disp_ready_o), 32'd1);
`ifdef IQ_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive, compare with the model, then advance the model.
  task automatic step(input bit [DW-1:0] dv, input bit ir_in, input bit fl,
                      input bit [DEPTH-1:0] wake);
    bit [DEPTH-1:0] free, cand, exp_upd, exp_sel;
    bit             dr, load, ir;
    int             fc, oldest;
    int             slots [$];
    ir = fl ? 1'b0 : ir_in;
    @(negedge clk);
    m_rdy = m_rdy | (wake & m_valid);
    disp_valid_i  = dv;
    issue_ready_i = ir;
    flush         = fl;
    entry_valid_i = m_valid;
    entry_rdy_i   = m_rdy | (~m_valid & DEPTH'($urandom));
    #1;
    free = ~m_valid;
    fc = 0;
    for (int e = 0; e < DEPTH; e++) if (free[e]) begin fc++; slots.push_back(e); end
    dr = !fl && (fc >= DW);
    exp_upd = '0;
    if (dr) for (int k = 0; k < DW; k++) if (dv[k]) exp_upd[slots[k]] = 1'b1;
    cand = m_valid & m_rdy & ~m_pend;
    oldest = -1;
    for (int e = 0; e < DEPTH; e++)
      if (cand[e] && (oldest < 0 || m_stamp[e] < m_stamp[oldest])) oldest = e;
    load = (!m_iv || ir) && (oldest >= 0) && !fl;
    exp_sel = '0;
    if (fl) exp_sel = '1;
    else if (load) exp_sel[oldest] = 1'b1;

    check("free_cnt", 32'(free_cnt_o), fc);
    check("disp_ready", 32'(disp_ready_o), 32'(dr));
    check("updata", 32'(updata_o), 32'(exp_upd));
    check("sel", 32'(sel_o), 32'(exp_sel));
    check("issue_valid", 32'(issue_valid_o), 32'(m_iv));
    if (m_iv) check("issue_idx_hold", 32'(issue_idx_o), m_iidx);
    if (dr) for (int k = 0; k < DW; k++)
      check("disp_idx", 32'(disp_idx_o[k*IW +: IW]), slots[k]);
`ifdef IQ_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, m_stall);
    if (dv[0] && !dr) m_stall++;
`endif

    // Issue stage
    if (fl) begin
      if (m_iv) void'(exp_q.pop_back());
      m_iv = 1'b0;
    end else if (load) begin
      m_iv = 1'b1; m_iidx = oldest; exp_q.push_back(oldest);
    end else if (ir) begin
      m_iv = 1'b0;
    end
    // Entries: a strobed entry leaves one cycle after its strobe
    for (int e = 0; e < DEPTH; e++)
      if (!exp_upd[e] && m_pend[e]) begin m_valid[e] = 1'b0; m_rdy[e] = 1'b0; end
    for (int k = 0; k < DW; k++)
      if (dr && dv[k]) begin
        m_valid[slots[k]] = 1'b1; m_rdy[slots[k]] = 1'b0;
        m_stamp[slots[k]] = stamp_ctr; stamp_ctr++;
      end
    m_pend = exp_sel;
  endtask

  // Monitor: compare each handed-off instruction against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && issue_valid_o && issue_ready_i) begin
        if (exp_q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL issue_orphan: got idx %0d expected no issue at %0t", issue_idx_o, $time);
        end else begin
          check("issue_order", 32'(issue_idx_o), exp_q.pop_front());
        end
      end
    end
  end

  function automatic bit [DEPTH-1:0] rand_mask(input int pct);
    bit [DEPTH-1:0] m;
    m = '0;
    for (int e = 0; e < DEPTH; e++) m[e] = ($urandom_range(0, 99) < pct);
    return m;
  endfunction

  initial begin
    bit [DW-1:0] dv;
    int          ir_pct, wake_pct, disp_pct;
    rst_n = 1'b1; flush = 1'b0; disp_valid_i = '0; issue_ready_i = 1'b0;
    entry_valid_i = '0; entry_rdy_i = '0;
    model_clear();
    do_reset();

    // Two-slot dispatch into an empty queue takes entries 0 and 1
    step(2'b11, 1'b0, 1'b0, '0);
    check("first_disp_idx", 32'(disp_idx_o), 32'h08);
    check("first_updata", 32'(updata_o), 32'h03);
    // Fill the rest, then try a dispatch into the full queue
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, '0);
    step(2'b11, 1'b0, 1'b0, '0);
    check("full_disp_ready", 32'(disp_ready_o), 32'd0);
    // Everything ready: issues 0..7 back to back
    for (int i = 0; i < 11; i++) step(2'b00, 1'b1, 1'b0, '1);

    // Flush with 5 valid entries and a loaded issue stage
    step(2'b11, 1'b0, 1'b0, '0);
    step(2'b11, 1'b0, 1'b0, '0);
    step(2'b01, 1'b0, 1'b0, '0);
    step(2'b00, 1'b0, 1'b0, '1);
    step(2'b00, 1'b0, 1'b1, '0);
    check("flush_sel_all", 32'(sel_o), 32'hFF);
    step(2'b00, 1'b0, 1'b0, '0);
    check("flush_issue_valid", 32'(issue_valid_o), 32'd0);
    step(2'b00, 1'b0, 1'b0, '0);
    check("flush_free_cnt", 32'(free_cnt_o), DEPTH);

    // Randomized traffic in several pressure phases, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        ir_pct   = $urandom_range(20, 100);
        wake_pct = $urandom_range(10, 90);
        disp_pct = $urandom_range(20, 100);
      end
      if (i == 1500) do_reset();
      dv = '0;
      if ($urandom_range(0, 99) < disp_pct) dv = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b11;
      step(dv, ($urandom_range(0, 99) < ir_pct), ($urandom_range(0, 99) == 0),
           rand_mask(wake_pct));
    end

    // Drain everything; nothing must remain pending in the scoreboard
    step(2'b00, 1'b0, 1'b1, '0);
    for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 1'b0, '0);
    check("drain_free_cnt", 32'(free_cnt_o), DEPTH);
    check("drain_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_alloc_sel_ctrl.md
Name: iq_alloc_sel_ctrl

Overview:
- Controller for one issue queue built from IQ_DEPTH static entries, each with one sel strobe and one update strobe.
- Allocates free entries to dispatched instructions, up to DISP_WIDTH per cycle, all-or-nothing.
- Tracks relative age with an age matrix and selects the oldest ready entry into a one-deep registered issue stage with valid/ready backpressure.
- Flush empties the queue by strobing sel to every entry.

Parameters:
IQ_DEPTH, 8, number of entries; power of two, 4..16.
DISP_WIDTH, 2, dispatch slots per cycle; 1..2.
IDX_W, $clog2(IQ_DEPTH), entry index width (derived).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  pipeline flush.
disp_valid_i  in  DISP_WIDTH  per-slot dispatch request; requests are packed (slot1 valid implies slot0 valid).
disp_ready_o  out  1  whole dispatch group accepted this cycle.
disp_idx_o  out  DISP_WIDTH*IDX_W  entry index allocated to each slot.
updata_o  out  IQ_DEPTH  per-entry write strobe (to entry updata_i).
entry_valid_i  in  IQ_DEPTH  entry valid_inst_o.
entry_rdy_i  in  IQ_DEPTH  entry operands all woken.
sel_o  out  IQ_DEPTH  per-entry issue/clear strobe (to entry sel_i).
issue_valid_o  out  1  issue stage holds an instruction.
issue_idx_o  out  IDX_W  entry index of issued instruction.
issue_ready_i  in  1  execution port accepts.
free_cnt_o  out  IDX_W+1  number of free entries (popcount of ~entry_valid_i).

Behaviour:
- Reset (async, rst_n=0): issue_valid_o=0, issue_idx_o=0, age matrix all 0. Combinational outputs then follow their inputs: disp_ready_o=1 and free_cnt_o=IQ_DEPTH once entries report invalid.
- Free vector: free = ~entry_valid_i. An entry strobed by sel_o this cycle is not reusable until the next cycle.
- Allocation: disp_ready_o = ~flush & (free_cnt_o >= DISP_WIDTH).
  - Slot k takes the k-th lowest-index free entry; disp_idx_o is valid whenever disp_ready_o=1.
  - updata_o[e]=1 iff disp_ready_o & disp_valid_i[k] and slot k maps to e.
  - Partial acceptance never occurs.
- Age matrix: age[i][j]=1 means i is older than j. On allocating e:
  - age[e][*]=0.
  - age[*][e]=1 for every j with entry_valid_i[j] & ~sel_o[j].
  - Same-cycle allocations: slot0 is older than slot1 (age[s0][s1]=1).
- Candidates: cand = entry_valid_i & entry_rdy_i & ~pending, where pending is the one-hot of the entry just strobed by sel_o in the previous cycle (its entry is still valid for that cycle).
- Selection: oldest = the i in cand with no j in cand having age[j][i]=1. Exactly one is chosen when cand != 0.
- Issue stage load: load = (~issue_valid_o | issue_ready_i) & (cand != 0) & ~flush.
  - On load: sel_o = onehot(oldest), issue_idx_o <= oldest, issue_valid_o <= 1.
  - Otherwise, if issue_ready_i=1: issue_valid_o <= 0.
  - Otherwise the stage holds; issue_idx_o is stable while issue_valid_o & ~issue_ready_i.
- Latency: entry ready at cycle t → sel_o at t, issue_valid_o at t+1. Back-to-back issue every cycle while issue_ready_i=1.
- Flush (sync, priority over everything):
  - sel_o = all ones, updata_o = 0, disp_ready_o = 0.
  - issue_valid_o <= 0, age matrix <= 0.
- Simultaneous events: sel and allocation on different entries in the same cycle are both honoured. Allocation never targets a valid entry, so there is no conflict on the same entry.
- Full queue: disp_ready_o=0 and selection continues. Empty queue: issue_valid_o drains to 0.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Optional Feature:
- Macro IQ_STALL_CNT_EN.
- When defined: adds output stall_cnt_o (32 bits), incremented each cycle disp_valid_i[0] & ~disp_ready_o. It wraps at 2^32, is cleared by reset, and is not cleared by flush.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, empty queue, DEPTH=8, dispatch 2 valid → disp_ready_o=1, disp_idx_o={1,0}, updata_o=8'h03, free_cnt_o=6 next cycle.
- Fill entries 0..7 in order, all ready, issue_ready_i=1 → issue_idx_o sequence 0,1,2,...,7 on consecutive cycles, each sel_o one-hot one cycle before.
- 7 valid entries, dispatch 2 → disp_ready_o=0, updata_o=0; after one issue frees an entry → accepted next cycle with both indices correct.
- issue_ready_i=0 for 3 cycles with issue_valid_o=1 → issue_idx_o stable, sel_o=0; on release, the next-oldest is loaded the same cycle.
- Younger entry ready before older: entry 5 (older) becomes ready one cycle after entry 2 (younger, reallocated) → entry 2 issues first; when both are ready the same cycle → entry 5 wins.
- Flush with 5 valid entries and issue_valid_o=1 → sel_o=8'hFF, issue_valid_o=0 next cycle, free_cnt_o=8 after entries clear; with IQ_STALL_CNT_EN, stall_cnt_o is preserved across the flush.
